// File: rtl/typing_countdown_timer.sv
// typing_countdown_timer: counts the typing-test period down from DURATION
// seconds to 0, one step per accepted tick_1hz strobe. It publishes the
// remaining time in binary and as a parallel BCD down-counter, together
// with the run/pause/done status used by the test control FSM.
//
// Optional build macro TYPING_TIMER_WARN_BLINK_EN:
//   defined   -> warn blinks, toggling on each accepted tick in the low-time window
//   undefined -> warn is a steady level while running in the low-time window
module typing_countdown_timer #(
    parameter int DURATION  = 60,
    parameter int WARN_SECS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    output logic [6:0] secs_left,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       running,
    output logic       paused,
    output logic       expired,
    output logic       done_pulse,
    output logic       warn
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Reload values are elaboration-time constants; no runtime divider exists.
    localparam logic [6:0] DUR_V      = 7'(DURATION);
    localparam logic [3:0] DUR_TENS   = 4'(DURATION / 10);
    localparam logic [3:0] DUR_ONES   = 4'(DURATION % 10);
    localparam logic [6:0] WARN_V     = 7'(WARN_SECS);
    localparam bit         DUR_IN_WIN = (DURATION <= WARN_SECS);

`ifdef TYPING_TIMER_WARN_BLINK_EN
    localparam bit WARN_BLINK = 1'b1;
`else
    localparam bit WARN_BLINK = 1'b0;
`endif

    // Binary decrement that holds at zero instead of wrapping.
    function automatic logic [6:0] sat_dec(input logic [6:0] v);
        if (v == 7'd0) return 7'd0;
        return v - 7'd1;
    endfunction

    // Two-digit BCD decrement: ones wraps 0 -> 9 with a borrow from tens,
    // and the pair holds at 00.
    function automatic logic [7:0] bcd_dec(input logic [3:0] tens, input logic [3:0] ones);
        if (ones == 4'd0) begin
            if (tens == 4'd0) return 8'h00;
            return {tens - 4'd1, 4'd9};
        end
        return {tens, ones - 4'd1};
    endfunction

    state_t     state;
    logic [6:0] secs_dec;
    logic [7:0] bcd_next;
    logic       last_sec;
    logic       dec_in_win;

    // Candidate values for the decrement taken on an accepted tick.
    always_comb begin
        secs_dec   = sat_dec(secs_left);
        bcd_next   = bcd_dec(bcd_tens, bcd_ones);
        last_sec   = (secs_left == 7'd1);
        dec_in_win = (secs_dec <= WARN_V);
    end

    // Control FSM; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            secs_left  <= DUR_V;
            bcd_tens   <= DUR_TENS;
            bcd_ones   <= DUR_ONES;
            running    <= 1'b0;
            paused     <= 1'b0;
            expired    <= 1'b0;
            done_pulse <= 1'b0;
            warn       <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                secs_left <= DUR_V;
                bcd_tens  <= DUR_TENS;
                bcd_ones  <= DUR_ONES;
                running   <= 1'b0;
                paused    <= 1'b0;
                expired   <= 1'b0;
                warn      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // A tick in the same cycle as start is deliberately dropped.
                        if (start) begin
                            state   <= RUNNING;
                            running <= 1'b1;
                            warn    <= WARN_BLINK ? 1'b0 : DUR_IN_WIN;
                        end
                    end
                    RUNNING: begin
                        if (tick_1hz) begin
                            secs_left <= secs_dec;
                            bcd_tens  <= bcd_next[7:4];
                            bcd_ones  <= bcd_next[3:0];
                            if (last_sec) begin
                                // Reaching zero overrides a simultaneous pause.
                                state      <= DONE;
                                running    <= 1'b0;
                                expired    <= 1'b1;
                                done_pulse <= 1'b1;
                                warn       <= 1'b0;
                            end else if (pause) begin
                                state   <= PAUSED;
                                running <= 1'b0;
                                paused  <= 1'b1;
                                warn    <= 1'b0;
                            end else if (WARN_BLINK) begin
                                warn <= dec_in_win ? ~warn : warn;
                            end else begin
                                warn <= dec_in_win;
                            end
                        end else if (pause) begin
                            state   <= PAUSED;
                            running <= 1'b0;
                            paused  <= 1'b1;
                            warn    <= 1'b0;
                        end
                    end
                    PAUSED: begin
                        if (pause) begin
                            state   <= RUNNING;
                            running <= 1'b1;
                            paused  <= 1'b0;
                            warn    <= WARN_BLINK ? 1'b0 : (secs_left <= WARN_V);
                        end
                    end
                    DONE: begin
                        // Restart directly from DONE without an abort.
                        if (start) begin
                            state     <= RUNNING;
                            secs_left <= DUR_V;
                            bcd_tens  <= DUR_TENS;
                            bcd_ones  <= DUR_ONES;
                            running   <= 1'b1;
                            expired   <= 1'b0;
                            warn      <= WARN_BLINK ? 1'b0 : DUR_IN_WIN;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
